// File: rtl/wb_rr_port_arbiter.sv
// wb_rr_port_arbiter
//
// Round-robin arbiter that lets N_REQ Wishbone masters share one slave port.
// A master owns the port from the cycle after it is chosen until it drops CYC,
// so burst cycles are never split. A watchdog aborts a grant whose slave never
// answers. It then pulses tout_err into the owner's ERR and bars that master
// until it drops CYC.
//
// Grant protocol: a master requests with cyc & stb. The grant appears one
// clock after the request is sampled and stays until cyc of the owner is seen
// low. At least one idle cycle separates consecutive grants.
//
// Parameters
//   N_REQ     number of masters (2..16)
//   TIMEOUT   stalled cycles before an abort; 0 disables the watchdog
//   ID_W      width of gnt_id
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rstn       asynchronous active-low reset
//   cyc, stb   per-master Wishbone CYC / STB
//   s_ack      ACK from the shared slave
//   s_err      ERR from the shared slave
//   gnt        one-hot grant, select for the master-to-slave mux
//   gnt_valid  high while any master is granted
//   gnt_id     index of the granted master; keeps its value while idle
//   tout_err   one-cycle ERR pulse to the granted master on a watchdog abort
//   lockout    masters barred after a watchdog abort
//   dbg_state  current FSM state (0 idle, 1 grant, 2 abort)

module wb_rr_port_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 256,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N_REQ-1:0] cyc,
    input  logic [N_REQ-1:0] stb,
    input  logic             s_ack,
    input  logic             s_err,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [ID_W-1:0]  gnt_id,
    output logic             tout_err,
    output logic [N_REQ-1:0] lockout,
    output logic [1:0]       dbg_state
);

    // A zero TIMEOUT would give a zero-width timer. One bit is kept so the
    // register stays legal; the watchdog compare is disabled in that case.
    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_MAX  = '1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);
    localparam logic [ID_W:0]    N_WIDE   = (ID_W + 1)'(N_REQ);
    localparam logic [ID_W-1:0]  LAST_RST = ID_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_ABORT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]    last_id_q, last_id_d;
    logic               tout_err_q, tout_err_d;
    logic [N_REQ-1:0]   lockout_q, lockout_d;
    logic [N_REQ-1:0]   lock_set;
    logic [TMR_W-1:0]   timer_q, timer_d;

    logic [N_REQ-1:0]   req;
    logic               owner_cyc;
    logic               pick_found;
    logic [ID_W-1:0]    pick_id;
    logic [ID_W:0]      cand;

    assign req       = cyc & stb & ~lockout_q;
    // gnt_q is one-hot, so this is cyc[gnt_id] without a variable index.
    assign owner_cyc = |(cyc & gnt_q);

    // Round-robin pick. The search starts just above the last grant and wraps.
    // The sum is one bit wider than an index, so the wrap can be done with a
    // single subtract.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = {1'b0, last_id_q} + (ID_W + 1)'(k);
            if (cand >= N_WIDE) begin
                cand = cand - N_WIDE;
            end
            if (!pick_found && req[cand[ID_W-1:0]]) begin
                pick_found = 1'b1;
                pick_id    = cand[ID_W-1:0];
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_id_d    = gnt_id_q;
        last_id_d   = last_id_q;
        tout_err_d  = 1'b0;
        timer_d     = timer_q;
        lock_set    = '0;

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (pick_found) begin
                    state_d     = S_GRANT;
                    gnt_d       = ONE_HOT0 << pick_id;
                    gnt_valid_d = 1'b1;
                    gnt_id_d    = pick_id;
                    last_id_d   = pick_id;
                end
            end

            S_GRANT: begin
                // A dropped cyc has priority over the watchdog. A slave
                // response has priority over expiry.
                if (!owner_cyc) begin
                    state_d     = S_IDLE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    timer_d     = '0;
                end else if (s_ack || s_err) begin
                    timer_d = '0;
                end else if ((TIMEOUT != 0) && (timer_q == TMR_LAST)) begin
                    state_d    = S_ABORT;
                    tout_err_d = 1'b1;
                end else if (timer_q != TMR_MAX) begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_ABORT: begin
                state_d     = S_IDLE;
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                timer_d     = '0;
                lock_set    = gnt_q;
            end

            default: begin
                state_d     = S_IDLE;
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                timer_d     = '0;
            end
        endcase

        // A lock set by an abort only sticks while that master still holds
        // cyc. Any master seen with cyc low is released.
        lockout_d = (lockout_q | lock_set) & cyc;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            last_id_q   <= LAST_RST;
            tout_err_q  <= 1'b0;
            lockout_q   <= '0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            last_id_q   <= last_id_d;
            tout_err_q  <= tout_err_d;
            lockout_q   <= lockout_d;
            timer_q     <= timer_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_id    = gnt_id_q;
    assign tout_err  = tout_err_q;
    assign lockout   = lockout_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_wb_rr_port_arbiter.sv
// Bench for wb_rr_port_arbiter. It runs two instances on shared stimulus:
// one with an 8-cycle watchdog and one with the watchdog disabled.
module tb_wb_rr_port_arbiter;

  localparam int N = 4;
  localparam int TO_A = 8;
  localparam int TO_B = 0;

  // clock / reset
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [N-1:0] cyc, stb;
  logic s_ack, s_err;

  logic [N-1:0] gnt_a, lock_a, gnt_b, lock_b;
  logic val_a, val_b, te_a, te_b;
  logic [1:0] id_a, id_b, st_a, st_b;

  int n_cmp = 0;
  int n_fail = 0;

  wb_rr_port_arbiter #(.N_REQ(N), .TIMEOUT(TO_A)) u_dut_a (
    .clk(clk), .rstn(rstn), .cyc(cyc), .stb(stb), .s_ack(s_ack), .s_err(s_err),
    .gnt(gnt_a), .gnt_valid(val_a), .gnt_id(id_a), .tout_err(te_a),
    .lockout(lock_a), .dbg_state(st_a)
  );

  wb_rr_port_arbiter #(.N_REQ(N), .TIMEOUT(TO_B)) u_dut_b (
    .clk(clk), .rstn(rstn), .cyc(cyc), .stb(stb), .s_ack(s_ack), .s_err(s_err),
    .gnt(gnt_b), .gnt_valid(val_b), .gnt_id(id_b), .tout_err(te_b),
    .lockout(lock_b), .dbg_state(st_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model. For each instance it tracks who owns the port, how
  // many granted cycles have passed with no slave answer, whether this cycle
  // is the abort pulse, the barred masters and the round-robin pointer.
  int m_owner[2];
  int m_stall[2];
  int m_last[2];
  int m_id[2];
  bit m_abort[2];
  logic [N-1:0] m_lock[2];

  function automatic logic bit_of(input logic [N-1:0] v, input int i);
    return v[i[1:0]];
  endfunction

  function automatic logic [N-1:0] exp_gnt(input int m);
    return (m_owner[m] >= 0) ? (4'b0001 << m_owner[m]) : 4'b0000;
  endfunction

  task automatic model_reset(input int m);
    m_owner[m] = -1;
    m_stall[m] = 0;
    m_last[m] = N - 1;
    m_id[m] = 0;
    m_abort[m] = 1'b0;
    m_lock[m] = '0;
  endtask

  // Advance one clock using the inputs that the coming edge will sample.
  task automatic model_step(input int m, input int to);
    logic [N-1:0] req;
    logic [N-1:0] nlock;
    int pick;
    int idx;
    req = cyc & stb & ~m_lock[m];
    nlock = m_lock[m] & cyc;
    if (m_abort[m]) begin
      if (bit_of(cyc, m_owner[m])) nlock = nlock | (4'b0001 << m_owner[m]);
      m_owner[m] = -1;
      m_abort[m] = 1'b0;
      m_stall[m] = 0;
    end else if (m_owner[m] >= 0) begin
      if (!bit_of(cyc, m_owner[m])) begin
        m_owner[m] = -1;
        m_stall[m] = 0;
      end else if (s_ack || s_err) begin
        m_stall[m] = 0;
      end else begin
        m_stall[m]++;
        if (to != 0 && m_stall[m] == to) m_abort[m] = 1'b1;
      end
    end else begin
      pick = -1;
      for (int k = 1; k <= N; k++) begin
        idx = (m_last[m] + k) % N;
        if (pick < 0 && bit_of(req, idx)) pick = idx;
      end
      if (pick >= 0) begin
        m_owner[m] = pick;
        m_last[m] = pick;
        m_id[m] = pick;
        m_stall[m] = 0;
      end
    end
    m_lock[m] = nlock;
  endtask

  // Scoreboard: compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    if (!rstn) begin
      model_reset(0);
      model_reset(1);
    end
    check("gnt_a", gnt_a, exp_gnt(0));
    check("valid_a", val_a, m_owner[0] >= 0);
    check("id_a", id_a, m_id[0]);
    check("tout_a", te_a, m_abort[0]);
    check("lock_a", lock_a, m_lock[0]);
    check("gnt_b", gnt_b, exp_gnt(1));
    check("valid_b", val_b, m_owner[1] >= 0);
    check("id_b", id_b, m_id[1]);
    check("tout_b", te_b, m_abort[1]);
    check("lock_b", lock_b, m_lock[1]);
    if (rstn) begin
      model_step(0, TO_A);
      model_step(1, TO_B);
    end
  end

  // driver: advance n rising edges, then settle 1 time unit
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    cyc = '0; stb = '0; s_ack = 1'b0; s_err = 1'b0;
    tick(2);
    check("rst_gnt", gnt_a, 4'b0000);
    check("rst_id", id_a, 2'd0);
    check("rst_lock", lock_a, 4'b0000);
    check("rst_tout", te_a, 1'b0);
    rstn = 1'b1;
    tick(1);

    // Requests from m1 and m3: m1 first, then m3 after one idle cycle.
    cyc = 4'b1010; stb = 4'b1010;
    tick(1);
    check("t1_gnt_m1", gnt_a, 4'b0010);
    check("t1_id_m1", id_a, 2'd1);
    tick(2);
    cyc = 4'b1000; stb = 4'b1000;
    tick(1);
    check("t1_idle", gnt_a, 4'b0000);
    check("t1_idle_id", id_a, 2'd1);
    tick(1);
    check("t1_gnt_m3", gnt_a, 4'b1000);
    cyc = '0; stb = '0;
    tick(2);

    // All four request. Each owner holds 3 cycles with ACK every cycle.
    cyc = 4'b1111; stb = 4'b1111; s_ack = 1'b1;
    for (int g = 0; g < 5; g++) begin
      tick(1);
      check("rr_grant", gnt_a, 4'b0001 << (g % 4));
      for (int h = 0; h < 2; h++) begin
        tick(1);
        check("rr_hold", gnt_a, 4'b0001 << (g % 4));
      end
      cyc = cyc & ~(4'b0001 << (g % 4));
      stb = stb & ~(4'b0001 << (g % 4));
      tick(1);
      check("rr_release", gnt_a, 4'b0000);
      cyc = cyc | (4'b0001 << (g % 4));
      stb = stb | (4'b0001 << (g % 4));
    end
    cyc = '0; stb = '0; s_ack = 1'b0;
    tick(2);

    // m2 granted and the slave never answers.
    cyc = 4'b0100; stb = 4'b0100;
    tick(1);
    check("to_gnt_m2", gnt_a, 4'b0100);
    tick(7);
    check("to_c8_tout", te_a, 1'b0);
    tick(1);
    check("to_c9_tout", te_a, 1'b1);
    check("to_c9_gnt", gnt_a, 4'b0100);
    tick(1);
    check("to_c10_gnt", gnt_a, 4'b0000);
    check("to_c10_tout", te_a, 1'b0);
    check("to_c10_lock", lock_a, 4'b0100);
    check("to_c10_hold_b", gnt_b, 4'b0100);
    tick(2);
    check("to_lock_held", lock_a, 4'b0100);
    check("to_lock_nogrant", gnt_a, 4'b0000);
    cyc = '0; stb = '0;
    tick(1);
    check("to_lock_clr", lock_a, 4'b0000);

    // m1 granted; ACK lands exactly in the expiry cycle.
    cyc = 4'b0010; stb = 4'b0010;
    tick(1);
    check("ack_gnt_m1", gnt_a, 4'b0010);
    tick(7);
    s_ack = 1'b1;
    tick(1);
    s_ack = 1'b0;
    check("ack_no_tout", te_a, 1'b0);
    check("ack_gnt_kept", gnt_a, 4'b0010);
    tick(7);
    check("ack_c16_tout", te_a, 1'b0);
    tick(1);
    check("ack_c17_tout", te_a, 1'b1);
    tick(1);
    check("ack_lock_m1", lock_a, 4'b0010);

    // m1 is barred, so m3 wins. Then reset is pulsed between clock edges.
    cyc = 4'b1010; stb = 4'b1010;
    tick(1);
    check("lk_gnt_m3", gnt_a, 4'b1000);
    #2;
    rstn = 1'b0;
    #1;
    check("ar_gnt", gnt_a, 4'b0000);
    check("ar_valid", val_a, 1'b0);
    check("ar_lock", lock_a, 4'b0000);
    check("ar_gnt_b", gnt_b, 4'b0000);
    tick(1);
    cyc = 4'b1111; stb = 4'b1111;
    rstn = 1'b1;
    tick(1);
    check("ar_first_m0", gnt_a, 4'b0001);
    check("ar_first_m0_b", gnt_b, 4'b0001);

    // m0 stalls for 1000 cycles.
    cyc = 4'b0001; stb = 4'b0001;
    tick(1000);
    check("st_gnt_b", gnt_b, 4'b0001);
    check("st_tout_b", te_b, 1'b0);
    check("st_gnt_a", gnt_a, 4'b0000);
    check("st_lock_a", lock_a, 4'b0001);
    cyc = '0; stb = '0;
    tick(2);

    // Single requester: re-grant after one idle cycle. ERR during idle is ignored.
    cyc = 4'b0100; stb = 4'b0100; s_err = 1'b1;
    tick(1);
    s_err = 1'b0;
    check("sr_gnt", gnt_a, 4'b0100);
    cyc = '0; stb = '0;
    tick(1);
    check("sr_idle", gnt_a, 4'b0000);
    cyc = 4'b0100; stb = 4'b0100;
    tick(1);
    check("sr_regnt", gnt_a, 4'b0100);
    check("sr_regnt_id", id_a, 2'd2);
    cyc = '0; stb = '0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_rr_port_arbiter.md
WB_RR_PORT_ARBITER -- requirements
Module: wb_rr_port_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesting masters sharing one slave port; legal range 2..16.
REQ-002 Parameter TIMEOUT, default 256: cycles without slave ACK/ERR before the grant is aborted; 0 disables the watchdog.
REQ-003 Parameter ID_W, default $clog2(N_REQ): width of gnt_id.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rstn  input  1  reset, asynchronous assert, active-low.
REQ-006 cyc  input  N_REQ  per-master Wishbone CYC.
REQ-007 stb  input  N_REQ  per-master Wishbone STB.
REQ-008 s_ack  input  1  ACK from the shared slave.
REQ-009 s_err  input  1  ERR from the shared slave.
REQ-010 gnt  output  N_REQ  one-hot grant, drives the master-to-slave mux select.
REQ-011 gnt_valid  output  1  OR of gnt.
REQ-012 gnt_id  output  ID_W  binary index of the granted master; holds its last value when gnt_valid=0.
REQ-013 tout_err  output  1  one-cycle ERR pulse, OR-ed by the mux into the granted master's ERR.
REQ-014 lockout  output  N_REQ  masters currently barred after a timeout.

Function
REQ-015 Request vector: req[i] = cyc[i] & stb[i] & ~lockout[i].
REQ-016 FSM states: IDLE, GRANT, ABORT; all outputs are registered.
REQ-017 IDLE: if req!=0, go to GRANT next edge; gnt = first set bit of req searching upward from last_id+1 with wrap-around (round-robin); last_id <= chosen index; timer cleared.
REQ-018 Grant latency: a request sampled at edge t yields gnt at t+1; no combinational path from req to gnt.
REQ-019 GRANT: gnt is held while cyc[gnt_id]=1, regardless of stb, so multi-beat/burst cycles (CTI) are never interrupted.
REQ-020 GRANT -> IDLE when cyc[gnt_id]=0; gnt clears on that edge, giving a minimum of one IDLE cycle between consecutive grants.
REQ-021 Timer (width $clog2(TIMEOUT+1)): cleared on grant entry and on any cycle with s_ack|s_err; otherwise increments while in GRANT; saturates and never wraps.
REQ-022 When TIMEOUT!=0 and the timer reaches TIMEOUT-1 with no s_ack/s_err in that cycle: go to ABORT and keep gnt unchanged.
REQ-023 ABORT lasts exactly one cycle: tout_err=1 and gnt held; then go to IDLE, clear gnt, and set lockout[gnt_id].
REQ-024 lockout[i] clears on the first edge on which cyc[i]=0.
REQ-025 An s_ack/s_err arriving in the same cycle the timer would expire wins: the timer clears and there is no abort.
REQ-026 Simultaneous cyc drop and expiry: the cyc drop wins; go to IDLE with no abort.
REQ-027 With a single persistent requester, re-grant happens after the one IDLE cycle; round-robin skips non-requesting indices.
REQ-028 s_ack/s_err in IDLE are ignored.

Reset
REQ-029 Asserting rstn=0 at any time (including mid-GRANT or ABORT) immediately forces: state=IDLE, gnt=0, gnt_valid=0, gnt_id=0, tout_err=0, lockout=0, timer=0, last_id=N_REQ-1 (so the first grant searches from index 0).
REQ-030 After rstn deasserts, the first grant decision occurs at the first posedge with req!=0.

Verification
REQ-031 Reset then cyc=stb=4'b1010 -> gnt=4'b0010, gnt_id=1 one cycle later; after m1 drops cyc: one IDLE cycle, then gnt=4'b1000.
REQ-032 All four masters request continuously, each holding cyc 3 cycles with an ACK each cycle -> grant order 0,1,2,3,0; gnt never changes while the owner's cyc=1.
REQ-033 TIMEOUT=8, m2 granted and slave never ACKs -> tout_err=1 exactly in cycle 9 after the grant, gnt=0 next cycle, lockout[2]=1 until cyc[2]=0.
REQ-034 TIMEOUT=8, s_ack arrives in the expiry cycle -> no tout_err; the timer restarts from 0.
REQ-035 rstn pulsed low mid-GRANT (asynchronously, between edges) -> gnt=0 and lockout=0 immediately; after release with req=4'b1111, the grant goes to m0.
REQ-036 TIMEOUT=0, slave stalls for 1000 cycles -> grant held and tout_err never asserted.
